// File: rtl/pwm.sv
// ============================================================================
// pwm : single-channel fixed-frequency PWM with decimal duty readout on HEX
// Revision: 1.0
// ============================================================================
`default_nettype none

module pwm #(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int DUTY_FREQ = 50
) (
  input  logic       MAX10_CLK1_50,
  input  logic [1:0] KEY,
  input  logic [9:0] SW,
  output logic [6:0] HEX0,
  output logic [6:0] HEX1,
  output logic [6:0] HEX2,
  output logic [9:0] GPIO
);

  localparam int PERIOD = CLK_FREQ / DUTY_FREQ;
  localparam int CW     = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int TW     = CW + 7;
  localparam logic [CW-1:0] LAST_CNT = CW'(PERIOD - 1);
  localparam logic [TW-1:0] STEP     = TW'(PERIOD / 100);

  logic clk;
  assign clk = MAX10_CLK1_50;

  // Reset asserts asynchronously, releases on a clock edge.
  logic [1:0] rst_sync_q;
  logic       rst_n;

  always_ff @(posedge clk or negedge KEY[0]) begin
    if (!KEY[0]) rst_sync_q <= 2'b00;
    else         rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

  logic [6:0]    sw_s1_q, sw_s2_q;
  logic          hold_s1_q, hold_s2_q;
  logic [6:0]    duty_req_q, duty_req_d;
  logic [6:0]    duty_act_q, duty_act_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [TW-1:0] thresh_d;
  logic          pwm_q, pwm_d;
  logic          strobe_q, strobe_d;
  logic          unused_sw;

  assign unused_sw = ^SW[9:7];

  // Next state is computed from the next counter/duty so that the registered
  // output is high exactly while cnt_q < duty_act_q * STEP.
  always_comb begin
    duty_req_d = duty_req_q;
    if (hold_s2_q) duty_req_d = (sw_s2_q > 7'd100) ? 7'd100 : sw_s2_q;
    cnt_d      = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    duty_act_d = (cnt_q == LAST_CNT) ? duty_req_q : duty_act_q;
    thresh_d   = TW'(duty_act_d) * STEP;
    pwm_d      = ({7'd0, cnt_d} < thresh_d);
    strobe_d   = (cnt_d == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1_q    <= '0;
      sw_s2_q    <= '0;
      hold_s1_q  <= 1'b0;
      hold_s2_q  <= 1'b0;
      duty_req_q <= '0;
      duty_act_q <= '0;
      cnt_q      <= '0;
      pwm_q      <= 1'b0;
      strobe_q   <= 1'b0;
    end else begin
      sw_s1_q    <= SW[6:0];
      sw_s2_q    <= sw_s1_q;
      hold_s1_q  <= KEY[1];
      hold_s2_q  <= hold_s1_q;
      duty_req_q <= duty_req_d;
      duty_act_q <= duty_act_d;
      cnt_q      <= cnt_d;
      pwm_q      <= pwm_d;
      strobe_q   <= strobe_d;
    end
  end

  assign GPIO = {8'd0, strobe_q, pwm_q};

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'b1000000;
      4'd1:    seg7 = 7'b1111001;
      4'd2:    seg7 = 7'b0100100;
      4'd3:    seg7 = 7'b0110000;
      4'd4:    seg7 = 7'b0011001;
      4'd5:    seg7 = 7'b0010010;
      4'd6:    seg7 = 7'b0000010;
      4'd7:    seg7 = 7'b1111000;
      4'd8:    seg7 = 7'b0000000;
      4'd9:    seg7 = 7'b0010000;
      default: seg7 = 7'b1111111;
    endcase
  endfunction

  logic       hund;
  logic [6:0] rem;
  logic [3:0] tens, ones;

  always_comb begin
    hund = (duty_act_q >= 7'd100);
    rem  = hund ? (duty_act_q - 7'd100) : duty_act_q;
    tens = 4'(rem / 7'd10);
    ones = 4'(rem % 7'd10);
  end

  assign HEX0 = seg7(ones);
  assign HEX1 = seg7(tens);
  assign HEX2 = seg7({3'd0, hund});

endmodule

`default_nettype wire

// File: tb/tb_pwm.sv
// ============================================================================
// tb_pwm : directed self-checking bench for pwm (PERIOD = 100, step = 1)
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_pwm;

  logic       clk;
  logic [1:0] key;
  logic [9:0] sw;
  logic [6:0] hex0, hex1, hex2;
  logic [9:0] gpio;

  int checks = 0;
  int errors = 0;

  localparam logic [6:0] S0 = 7'b1000000;
  localparam logic [6:0] S1 = 7'b1111001;
  localparam logic [6:0] S2 = 7'b0100100;
  localparam logic [6:0] S4 = 7'b0011001;
  localparam logic [6:0] S5 = 7'b0010010;

  pwm #(.CLK_FREQ(1000), .DUTY_FREQ(10)) dut (
    .MAX10_CLK1_50(clk),
    .KEY          (key),
    .SW           (sw),
    .HEX0         (hex0),
    .HEX1         (hex1),
    .HEX2         (hex2),
    .GPIO         (gpio)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic chk_hex(input string tag, input logic [6:0] h2, input logic [6:0] h1,
                         input logic [6:0] h0);
    chk({tag, "_hex2"}, {25'd0, hex2}, {25'd0, h2});
    chk({tag, "_hex1"}, {25'd0, hex1}, {25'd0, h1});
    chk({tag, "_hex0"}, {25'd0, hex0}, {25'd0, h0});
  endtask

  task automatic adv(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Locate a period start, then count high cycles over one full period.
  task automatic measure(input string tag, input int exp_high, input int chg_at,
                         input logic [9:0] chg_sw);
    int high;
    int strobes;
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (gpio[1]) begin
        found = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    chk({tag, "_found"}, {31'd0, found}, 32'd1);
    high    = 0;
    strobes = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == chg_at) sw = chg_sw;
      high    += int'(gpio[0]);
      strobes += int'(gpio[1]);
      @(posedge clk);
      #1;
    end
    chk({tag, "_high"}, high, exp_high);
    chk({tag, "_strobes"}, strobes, 32'd1);
    chk({tag, "_wrap"}, {31'd0, gpio[1]}, 32'd1);
  endtask

  initial begin
    key = 2'b00;
    sw  = 10'd0;
    adv(3);
    chk("rst_gpio", {22'd0, gpio}, 32'd0);
    chk_hex("rst", S0, S0, S0);

    key = 2'b11;
    measure("boot", 0, -1, 10'd0);

    sw = 10'd25;
    adv(4);
    measure("d25", 25, -1, 10'd0);
    chk_hex("d25", S0, S2, S5);

    sw = 10'd100;
    adv(4);
    measure("d100a", 100, -1, 10'd0);
    measure("d100b", 100, -1, 10'd0);
    chk_hex("d100", S1, S0, S0);

    sw = 10'd0;
    adv(4);
    measure("d0", 0, -1, 10'd0);
    chk_hex("d0", S0, S0, S0);

    sw = 10'd127;
    adv(4);
    measure("d127", 100, -1, 10'd0);
    chk_hex("d127", S1, S0, S0);

    sw = 10'd40;
    adv(4);
    measure("d40", 40, -1, 10'd0);
    key = 2'b01;
    adv(4);
    sw = 10'd70;
    adv(6);
    measure("hold", 40, -1, 10'd0);
    chk_hex("hold", S0, S4, S0);
    key = 2'b11;
    adv(4);
    measure("unhold", 70, -1, 10'd0);

    sw = 10'd50;
    adv(4);
    measure("d50", 50, -1, 10'd0);
    measure("mid_chg", 50, 30, 10'd10);
    measure("d10", 10, -1, 10'd0);

    sw = 10'd60;
    adv(4);
    measure("d60", 60, -1, 10'd0);
    adv(10);
    chk("pre_rst_high", {31'd0, gpio[0]}, 32'd1);
    #2;
    key = 2'b10;
    #1;
    chk("async_rst_gpio", {22'd0, gpio}, 32'd0);
    chk_hex("async_rst", S0, S0, S0);
    adv(2);
    key = 2'b11;
    adv(5);
    chk("restart_gpio", {22'd0, gpio}, 32'd0);
    measure("post_rst", 60, -1, 10'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
